aucohl_uart_rx: RTL and testbench

Oversampling UART receive framer. It turns the asynchronous serial `rx` line into parallel words and drives the write side of the receive FIFO directly (`wdata`/`wr`, with `full` returned as `fifo_full`). It owns baud-tick generation, start validation, mid-bit sampling, stop/parity checking and error reporting. It sits between the pad-side `rx` input and the RX FIFO.

---
 rtl/aucohl_uart_rx.sv | 161 ++++++++++++++++
 tb/tb_aucohl_uart_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aucohl_uart_rx.sv
// aucohl_uart_rx: oversampling UART receive framer driving the RX FIFO write port.
// Define AUCOHL_UART_RX_PARITY_EN to build the optional parity state and checker.
module aucohl_uart_rx #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          rx,
    input  logic [15:0]   prescaler,
    input  logic          parity_en,
    input  logic          parity_odd,
    input  logic          fifo_full,
    output logic [DW-1:0] wdata,
    output logic          wr,
    output logic          frame_err,
    output logic          parity_err,
    output logic          overrun_err,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef AUCOHL_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DW - 1);

    state_t        state, state_n;
    logic          rx_meta, rxs;
    logic [15:0]   pcnt;
    logic [3:0]    sc;
    logic [3:0]    bit_idx;
    logic [DW-1:0] shreg;
    logic          par_bad;
    logic          tick, sample, detect;
    logic          wr_n, ferr_n, perr_n, oerr_n;

    assign tick   = (pcnt == '0);
    assign sample = tick && (sc == 4'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        detect  = 1'b0;
        wr_n    = 1'b0;
        ferr_n  = 1'b0;
        perr_n  = 1'b0;
        oerr_n  = 1'b0;
        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (!rxs) begin
                    state_n = START;
                    detect  = 1'b1;
                end
                START: if (sample) state_n = rxs ? IDLE : DATA;
                DATA: if (sample && bit_idx == LAST_BIT) begin
`ifdef AUCOHL_UART_RX_PARITY_EN
                    state_n = parity_en ? PARITY : STOP;
`else
                    state_n = STOP;
`endif
                end
`ifdef AUCOHL_UART_RX_PARITY_EN
                PARITY: if (sample) state_n = STOP;
`endif
                // Stop is judged at mid-bit; its second half is not waited out.
                STOP: if (sample) begin
                    if (!rxs) begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end else begin
                        state_n = IDLE;
                        if (par_bad)        perr_n = 1'b1;
                        else if (fifo_full) oerr_n = 1'b1;
                        else                wr_n   = 1'b1;
                    end
                end
                WAIT_HIGH: if (rxs) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            sc      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (detect) begin
                pcnt <= prescaler;
                sc   <= '0;
            end else begin
                pcnt <= tick ? prescaler : pcnt - 16'd1;
                if (tick) sc <= sc + 4'd1;
            end
            if (state == START && sample) bit_idx <= '0;
            if (state == DATA && sample) begin
                shreg   <= {rxs, shreg[DW-1:1]};
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

`ifdef AUCOHL_UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      par_bad <= 1'b0;
        else if (detect)                 par_bad <= 1'b0;
        else if (state == PARITY && sample)
            par_bad <= rxs ^ (^shreg) ^ parity_odd;
    end
`else
    logic unused_parity;
    assign par_bad       = 1'b0;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    // wdata is only driven alongside wr so idle/aborted states read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata       <= '0;
            wr          <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wdata       <= wr_n ? shreg : '0;
            wr          <= wr_n;
            frame_err   <= ferr_n;
            parity_err  <= perr_n;
            overrun_err <= oerr_n;
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_aucohl_uart_rx.sv
// Directed bench for aucohl_uart_rx: table of 8N1 frames plus hand-written corner sequences.
module tb_aucohl_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] presc = 16'd0;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        fifo_full = 1'b0;
    logic [7:0]  wdata;
    logic        wr, frame_err, parity_err, overrun_err, busy;

    aucohl_uart_rx #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rx(rx), .prescaler(presc),
        .parity_en(parity_en), .parity_odd(parity_odd), .fifo_full(fifo_full),
        .wdata(wdata), .wr(wr), .frame_err(frame_err), .parity_err(parity_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_cnt = 0, ferr_cnt = 0, perr_cnt = 0, oerr_cnt = 0;
    int last_wr_cyc = 0;
    logic [7:0] wq[$];
    always @(negedge clk) begin
        if (wr) begin
            wr_cnt++;
            wq.push_back(wdata);
            last_wr_cyc = cyc;
        end
        if (frame_err)   ferr_cnt++;
        if (parity_err)  perr_cnt++;
        if (overrun_err) oerr_cnt++;
    end

    int n_checks = 0, n_pass = 0;
    int t0 = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bits(input int n);
        wait_cyc(n * 16 * (int'(presc) + 1));
    endtask

    // pbit < 0: no parity bit on the line
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int pbit);
        t0 = cyc;
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_bits(1);
        end
        if (pbit >= 0) begin
            rx = pbit[0];
            wait_bits(1);
        end
        rx = stop_b;
        wait_bits(1);
    endtask

    function automatic int wq_at(input int idx);
        if (idx < wq.size()) return int'(wq[idx]);
        return 32'hDEAD;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic [15:0] p;
        logic stop;
        logic full;
        int exp_wr;
        int exp_data;
        int exp_ferr;
        int exp_oerr;
        int exp_lat;
    } vec_t;

    vec_t vecs[6];

    int bw, bf, bp, bo;

    initial begin
        vecs[0] = '{8'hA5, 16'd0, 1'b1, 1'b0, 1, 32'hA5, 0, 0, 155};
        vecs[1] = '{8'h3C, 16'd1, 1'b0, 1'b0, 0, 0,      1, 0, 0};
        vecs[2] = '{8'h55, 16'd0, 1'b1, 1'b1, 0, 0,      0, 1, 0};
        vecs[3] = '{8'h00, 16'd2, 1'b1, 1'b0, 1, 32'h00, 0, 0, 0};
        vecs[4] = '{8'hFF, 16'd1, 1'b1, 1'b0, 1, 32'hFF, 0, 0, 0};
        vecs[5] = '{8'h80, 16'd0, 1'b1, 1'b0, 1, 32'h80, 0, 0, 0};

        wait_cyc(3);
        check("rst_wdata", int'(wdata), 0);
        check("rst_wr", int'(wr), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_perr", int'(parity_err), 0);
        check("rst_oerr", int'(overrun_err), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        en = 1'b1;
        wait_cyc(4);

        foreach (vecs[i]) begin
            presc = vecs[i].p;
            fifo_full = vecs[i].full;
            bw = wr_cnt; bf = ferr_cnt; bp = perr_cnt; bo = oerr_cnt;
            send_frame(vecs[i].d, vecs[i].stop, -1);
            rx = 1'b1;
            wait_bits(2);
            fifo_full = 1'b0;
            check($sformatf("v%0d_wr", i), wr_cnt - bw, vecs[i].exp_wr);
            if (vecs[i].exp_wr > 0)
                check($sformatf("v%0d_wdata", i), wq_at(bw), vecs[i].exp_data);
            if (vecs[i].exp_lat > 0)
                check($sformatf("v%0d_latency", i), last_wr_cyc - t0, vecs[i].exp_lat);
            check($sformatf("v%0d_ferr", i), ferr_cnt - bf, vecs[i].exp_ferr);
            check($sformatf("v%0d_oerr", i), oerr_cnt - bo, vecs[i].exp_oerr);
            check($sformatf("v%0d_perr", i), perr_cnt - bp, 0);
            check($sformatf("v%0d_busy", i), int'(busy), 0);
        end

        // 2-cycle glitch is a false start
        presc = 16'd3;
        bw = wr_cnt; bf = ferr_cnt;
        t0 = cyc;
        rx = 1'b0;
        wait_cyc(2);
        rx = 1'b1;
        wait_cyc(2);
        check("glitch_busy_hi", int'(busy), 1);
        wait_cyc(36);
        check("glitch_busy_lo", int'(busy), 0);
        wait_bits(12);
        check("glitch_wr", wr_cnt - bw, 0);
        check("glitch_ferr", ferr_cnt - bf, 0);

        // break: one frame error, held in WAIT_HIGH until the line recovers
        presc = 16'd1;
        bw = wr_cnt; bf = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1);
        wait_bits(40);
        check("break_ferr", ferr_cnt - bf, 1);
        check("break_busy_hi", int'(busy), 1);
        rx = 1'b1;
        wait_cyc(5);
        check("break_busy_lo", int'(busy), 0);
        wait_bits(2);
        check("break_ferr_after", ferr_cnt - bf, 1);
        check("break_wr", wr_cnt - bw, 0);

        // back-to-back frames
        presc = 16'd0;
        bw = wr_cnt;
        send_frame(8'h01, 1'b1, -1);
        send_frame(8'h02, 1'b1, -1);
        wait_bits(2);
        check("b2b_wr", wr_cnt - bw, 2);
        check("b2b_first", wq_at(bw), 32'h01);
        check("b2b_second", wq_at(bw + 1), 32'h02);

        // en dropped mid-DATA
        presc = 16'd1;
        bw = wr_cnt; bf = ferr_cnt; bo = oerr_cnt;
        rx = 1'b0;
        wait_bits(3);
        check("endrop_busy_before", int'(busy), 1);
        en = 1'b0;
        wait_cyc(1);
        check("endrop_busy", int'(busy), 0);
        check("endrop_wdata", int'(wdata), 0);
        wait_bits(8);
        rx = 1'b1;
        wait_bits(2);
        en = 1'b1;
        wait_cyc(2);
        check("endrop_pulses", (wr_cnt - bw) + (ferr_cnt - bf) + (oerr_cnt - bo), 0);
        send_frame(8'h96, 1'b1, -1);
        wait_bits(1);
        check("endrop_next_wr", wr_cnt - bw, 1);
        check("endrop_next_data", wq_at(bw), 32'h96);

        // asynchronous reset mid-frame
        bw = wr_cnt;
        rx = 1'b0;
        wait_bits(4);
        rst_n = 1'b0;
        wait_cyc(1);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_wr", int'(wr), 0);
        check("rstmid_wdata", int'(wdata), 0);
        rx = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_bits(1);
        send_frame(8'h69, 1'b1, -1);
        wait_bits(1);
        check("rstmid_next_wr", wr_cnt - bw, 1);
        check("rstmid_next_data", wq_at(bw), 32'h69);

`ifdef AUCOHL_UART_RX_PARITY_EN
        presc = 16'd0;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        bw = wr_cnt; bp = perr_cnt;
        send_frame(8'h07, 1'b1, 0);
        wait_bits(2);
        check("par_even_bad_perr", perr_cnt - bp, 1);
        check("par_even_bad_wr", wr_cnt - bw, 0);
        bw = wr_cnt; bp = perr_cnt;
        send_frame(8'h07, 1'b1, 1);
        wait_bits(2);
        check("par_even_ok_perr", perr_cnt - bp, 0);
        check("par_even_ok_wr", wr_cnt - bw, 1);
        check("par_even_ok_data", wq_at(bw), 32'h07);
        parity_odd = 1'b1;
        bw = wr_cnt; bp = perr_cnt;
        send_frame(8'h07, 1'b1, 0);
        wait_bits(2);
        check("par_odd_ok_wr", wr_cnt - bw, 1);
        check("par_odd_ok_perr", perr_cnt - bp, 0);
`else
        // parity controls are ignored without the parity build
        presc = 16'd0;
        parity_en = 1'b1;
        parity_odd = 1'b1;
        bw = wr_cnt; bp = perr_cnt;
        send_frame(8'h07, 1'b1, -1);
        wait_bits(2);
        check("nopar_wr", wr_cnt - bw, 1);
        check("nopar_data", wq_at(bw), 32'h07);
        check("nopar_perr", perr_cnt - bp, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
